// File: rtl/aq_dcache_op_seq.sv
// Dcache special-op sequencer: turns one CP0 dcache request into per-line
// commands to the array control. ALL walks every set/way; SW/VA/PA issue one line.
module aq_dcache_op_seq #(
  parameter int INDEX_W = 7,
  parameter int WAY_W   = 1,
  parameter int ADDR_W  = 40
) (
  input  logic                forever_cpuclk,
  input  logic                cpurst_b,
  input  logic                cp0_dcache_op_req,
  input  logic [1:0]          cp0_dcache_op_type,
  input  logic [1:0]          cp0_dcache_op_op,
  input  logic [ADDR_W-1:0]   cp0_dcache_op_addr,
  output logic                dcache_op_busy,
  output logic                dcache_op_done,
  output logic                seq_line_vld,
  output logic [1:0]          seq_line_op,
  output logic                seq_line_by_addr,
  output logic                seq_line_va,
  output logic [INDEX_W-1:0]  seq_line_idx,
  output logic [WAY_W-1:0]    seq_line_way,
  output logic [ADDR_W-1:0]   seq_line_addr,
  input  logic                line_seq_grnt,
  input  logic                line_seq_cmplt
);

  localparam logic [1:0] TYPE_ALL = 2'b00;
  localparam logic [1:0] TYPE_SW  = 2'b01;
  localparam logic [1:0] TYPE_VA  = 2'b10;
  localparam logic [1:0] OP_NOP   = 2'b00;
  localparam int         CNT_W    = INDEX_W + WAY_W;
  localparam logic [ADDR_W-1:0] LINE_MASK = {{(ADDR_W-6){1'b1}}, 6'b0};

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t              r_state;
  state_t              w_next;
  logic [1:0]          r_type;
  logic [1:0]          r_op;
  logic [ADDR_W-1:0]   r_addr;
  logic                r_by_addr;
  logic                r_va;
  logic [INDEX_W-1:0]  r_idx;
  logic [WAY_W-1:0]    r_way;
  logic [CNT_W-1:0]    w_cnt_nxt;
  logic                w_last;
  logic                w_accept;
  logic                w_advance;

  // Way is the low half of the counter so it wraps into the index.
  assign w_cnt_nxt = {r_idx, r_way} + {{(CNT_W-1){1'b0}}, 1'b1};
  assign w_last    = (&r_idx) && (&r_way);
  assign w_accept  = (r_state == IDLE) && cp0_dcache_op_req;
  assign w_advance = (r_state == WAIT) && line_seq_cmplt &&
                     (r_type == TYPE_ALL) && !w_last;

  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:  if (cp0_dcache_op_req) w_next = (cp0_dcache_op_op == OP_NOP) ? DONE : ISSUE;
      ISSUE: if (line_seq_grnt) w_next = WAIT;
      WAIT:  if (line_seq_cmplt) w_next = w_advance ? ISSUE : DONE;
      DONE:  w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      r_type    <= 2'b00;
      r_op      <= 2'b00;
      r_addr    <= '0;
      r_by_addr <= 1'b0;
      r_va      <= 1'b0;
      r_idx     <= '0;
      r_way     <= '0;
    end else if (w_accept) begin
      r_type <= cp0_dcache_op_type;
      r_op   <= cp0_dcache_op_op;
      r_addr <= cp0_dcache_op_addr;
      if (cp0_dcache_op_type == TYPE_SW) begin
        r_idx <= cp0_dcache_op_addr[INDEX_W+5:6];
        r_way <= cp0_dcache_op_addr[WAY_W+INDEX_W+5:INDEX_W+6];
      end else begin
        r_idx <= '0;
        r_way <= '0;
      end
      r_by_addr <= cp0_dcache_op_type[1];
      r_va      <= (cp0_dcache_op_type == TYPE_VA);
    end else if (w_advance) begin
      {r_idx, r_way} <= w_cnt_nxt;
    end
  end

  always_comb begin
    dcache_op_busy = (r_state != IDLE);
    dcache_op_done = (r_state == DONE);
    seq_line_vld   = (r_state == ISSUE);
  end

  assign seq_line_op      = r_op;
  assign seq_line_by_addr = r_by_addr;
  assign seq_line_va      = r_va;
  assign seq_line_idx     = r_idx;
  assign seq_line_way     = r_way;
  assign seq_line_addr    = r_addr & LINE_MASK;

endmodule

// File: tb/tb_aq_dcache_op_seq.sv
// Directed bench for aq_dcache_op_seq: a vector table of single-line ops
// plus hand sequences for ALL walks, request-while-busy and reset mid-walk.
module tb_aq_dcache_op_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req = 1'b0;
  logic [1:0]  typ = 2'b00;
  logic [1:0]  opc = 2'b00;
  logic [39:0] addr = '0;
  logic        grnt = 1'b0;
  logic        cmplt = 1'b0;
  logic        busy, done, vld, byAddr, va;
  logic [1:0]  lop;
  logic [6:0]  idx;
  logic [0:0]  way;
  logic [39:0] laddr;

  int checks = 0;
  int passes = 0;

  int nCmds, doneCnt, doneK, busyCnt, orderErrs, stableErrs, lastCmpltK;
  bit timedOut, didReset;
  logic [1:0]  fOp;
  logic        fBy, fVa, fWay;
  logic [6:0]  fIdx;
  logic [39:0] fAddr;

  typedef struct {
    string       name;
    logic [1:0]  t;
    logic [1:0]  o;
    logic [39:0] a;
    int          gDly;
    int          cDly;
    bit          tie;
    int          expCmds;
    int          expDone;
    logic        expBy;
    logic        expVa;
    logic [6:0]  expIdx;
    logic        expWay;
    logic [39:0] expAddr;
  } vec_t;

  vec_t vecs[6];

  aq_dcache_op_seq #(.INDEX_W(7), .WAY_W(1), .ADDR_W(40)) dut (
    .forever_cpuclk     (clk),
    .cpurst_b           (rst_n),
    .cp0_dcache_op_req  (req),
    .cp0_dcache_op_type (typ),
    .cp0_dcache_op_op   (opc),
    .cp0_dcache_op_addr (addr),
    .dcache_op_busy     (busy),
    .dcache_op_done     (done),
    .seq_line_vld       (vld),
    .seq_line_op        (lop),
    .seq_line_by_addr   (byAddr),
    .seq_line_va        (va),
    .seq_line_idx       (idx),
    .seq_line_way       (way),
    .seq_line_addr      (laddr),
    .line_seq_grnt      (grnt),
    .line_seq_cmplt     (cmplt)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Issues one request, then plays the array side until done (or a reset point).
  task automatic applyStimulus(input logic [1:0] t, input logic [1:0] o, input logic [39:0] a,
                               input int gDly, input int cDly, input bit rnd, input bit tie,
                               input int injK, input int rstIdx);
    int k;
    int gCnt;
    int cCnt;
    bit inCmd;
    bit pending;
    logic [7:0]  expSeq;
    logic [52:0] cur;
    logic [6:0]  curIdx;
    nCmds = 0; doneCnt = 0; doneK = 0; busyCnt = 0; orderErrs = 0;
    stableErrs = 0; lastCmpltK = 0; timedOut = 0; didReset = 0;
    gCnt = 0; cCnt = 0; inCmd = 0; pending = 0; cur = '0; curIdx = '0;
    @(negedge clk);
    req = 1'b1; typ = t; opc = o; addr = a; grnt = 1'b0; cmplt = 1'b0;
    @(negedge clk);
    req = 1'b0;
    k = 1;
    while (k < 4000) begin
      grnt = 1'b0;
      cmplt = 1'b0;
      req = (k == injK);
      if (k == injK) begin
        typ = 2'b01; opc = 2'b01; addr = '1;
      end
      if (busy) busyCnt++;
      if (done) begin
        doneCnt++;
        doneK = k;
      end
      if (vld) begin
        if (!inCmd) begin
          inCmd = 1'b1;
          cur = {lop, byAddr, va, idx, way, laddr};
          curIdx = idx;
          if (nCmds == 0) begin
            fOp = lop; fBy = byAddr; fVa = va; fIdx = idx; fWay = way; fAddr = laddr;
          end
          expSeq = nCmds[7:0];
          if (t == 2'b00 && {idx, way} != expSeq) orderErrs++;
          gCnt = rnd ? int'($urandom_range(0, gDly)) : gDly;
        end else if ({lop, byAddr, va, idx, way, laddr} != cur) begin
          stableErrs++;
        end
        if (tie || gCnt == 0) begin
          grnt = 1'b1;
          inCmd = 1'b0;
          pending = 1'b1;
          nCmds++;
          cCnt = rnd ? int'($urandom_range(0, cDly)) : cDly;
        end else begin
          gCnt--;
        end
      end else if (pending) begin
        if (rstIdx >= 0 && curIdx == rstIdx[6:0]) begin
          #2 rst_n = 1'b0;
          #1;
          checkOutput("rstVld", 64'(vld), 64'd0);
          checkOutput("rstBusy", 64'(busy), 64'd0);
          checkOutput("rstDone", 64'(done), 64'd0);
          didReset = 1'b1;
          break;
        end
        if (tie || cCnt == 0) begin
          cmplt = 1'b1;
          pending = 1'b0;
          lastCmpltK = k;
        end else begin
          cCnt--;
        end
      end
      if (tie) begin
        grnt = 1'b1;
        cmplt = 1'b1;
      end
      if (doneK > 0 && k == doneK + 1) begin
        checkOutput("busyAfterDone", 64'(busy), 64'd0);
        checkOutput("doneAfterDone", 64'(done), 64'd0);
        break;
      end
      @(negedge clk);
      k++;
    end
    grnt = 1'b0;
    cmplt = 1'b0;
    timedOut = (k >= 4000);
    checkOutput("noTimeout", 64'(timedOut), 64'd0);
  endtask

  initial begin
    vecs[0] = '{"vaCln", 2'b10, 2'b10, 40'h12_3456_78FF, 0, 0, 1'b1, 1, 3, 1'b1, 1'b1, 7'h00, 1'b0, 40'h12_3456_78C0};
    vecs[1] = '{"paInv", 2'b11, 2'b01, 40'hFF_FFFF_FFFF, 0, 0, 1'b1, 1, 3, 1'b1, 1'b0, 7'h00, 1'b0, 40'hFF_FFFF_FFC0};
    vecs[2] = '{"swCi", 2'b01, 2'b11, 40'h00_0000_3680, 4, 0, 1'b0, 1, 7, 1'b0, 1'b0, 7'h5A, 1'b1, 40'h00_0000_3680};
    vecs[3] = '{"swHiBits", 2'b01, 2'b01, 40'hAB_CDEF_2FFF, 0, 2, 1'b0, 1, 5, 1'b0, 1'b0, 7'h3F, 1'b1, 40'hAB_CDEF_2FC0};
    vecs[4] = '{"vaCiGdly", 2'b10, 2'b11, 40'h00_0000_0040, 1, 0, 1'b0, 1, 4, 1'b1, 1'b1, 7'h00, 1'b0, 40'h00_0000_0040};
    vecs[5] = '{"nop", 2'b00, 2'b00, 40'h00_0000_0000, 0, 0, 1'b0, 0, 1, 1'b0, 1'b0, 7'h00, 1'b0, 40'h0};

    repeat (2) @(negedge clk);
    checkOutput("rstBusy0", 64'(busy), 64'd0);
    checkOutput("rstDone0", 64'(done), 64'd0);
    checkOutput("rstVld0", 64'(vld), 64'd0);
    checkOutput("rstFields0", 64'({lop, byAddr, va, idx, way}), 64'd0);
    checkOutput("rstAddr0", 64'(laddr), 64'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 6; i++) begin
      applyStimulus(vecs[i].t, vecs[i].o, vecs[i].a, vecs[i].gDly, vecs[i].cDly, 1'b0, vecs[i].tie, -1, -1);
      checkOutput($sformatf("%s_cmds", vecs[i].name), 64'(nCmds), 64'(vecs[i].expCmds));
      checkOutput($sformatf("%s_doneCnt", vecs[i].name), 64'(doneCnt), 64'd1);
      checkOutput($sformatf("%s_doneK", vecs[i].name), 64'(doneK), 64'(vecs[i].expDone));
      checkOutput($sformatf("%s_busyCycles", vecs[i].name), 64'(busyCnt), 64'(vecs[i].expDone));
      if (vecs[i].expCmds > 0) begin
        checkOutput($sformatf("%s_op", vecs[i].name), 64'(fOp), 64'(vecs[i].o));
        checkOutput($sformatf("%s_byAddr", vecs[i].name), 64'(fBy), 64'(vecs[i].expBy));
        checkOutput($sformatf("%s_va", vecs[i].name), 64'(fVa), 64'(vecs[i].expVa));
        checkOutput($sformatf("%s_idx", vecs[i].name), 64'(fIdx), 64'(vecs[i].expIdx));
        checkOutput($sformatf("%s_way", vecs[i].name), 64'(fWay), 64'(vecs[i].expWay));
        checkOutput($sformatf("%s_addr", vecs[i].name), 64'(fAddr), 64'(vecs[i].expAddr));
        checkOutput($sformatf("%s_stable", vecs[i].name), 64'(stableErrs), 64'd0);
        checkOutput($sformatf("%s_doneAfterCmplt", vecs[i].name), 64'(doneK), 64'(lastCmpltK + 1));
      end
    end

    // Full walk with random array latency.
    applyStimulus(2'b00, 2'b01, 40'h0, 3, 3, 1'b1, 1'b0, -1, -1);
    checkOutput("allInv_cmds", 64'(nCmds), 64'd256);
    checkOutput("allInv_order", 64'(orderErrs), 64'd0);
    checkOutput("allInv_stable", 64'(stableErrs), 64'd0);
    checkOutput("allInv_doneCnt", 64'(doneCnt), 64'd1);
    checkOutput("allInv_doneAfterCmplt", 64'(doneK), 64'(lastCmpltK + 1));
    checkOutput("allInv_busyCycles", 64'(busyCnt), 64'(doneK));

    // Second request pulsed while a PA op is waiting for grant.
    applyStimulus(2'b11, 2'b10, 40'h01_0000_0080, 3, 1, 1'b0, 1'b0, 2, -1);
    checkOutput("busyReq_cmds", 64'(nCmds), 64'd1);
    checkOutput("busyReq_doneCnt", 64'(doneCnt), 64'd1);
    checkOutput("busyReq_doneK", 64'(doneK), 64'd7);
    checkOutput("busyReq_stable", 64'(stableErrs), 64'd0);
    checkOutput("busyReq_fields", 64'({fOp, fBy, fVa}), 64'({2'b10, 1'b1, 1'b0}));
    checkOutput("busyReq_addr", 64'(fAddr), 64'h01_0000_0080);
    repeat (3) @(negedge clk);
    checkOutput("busyReq_idleBusy", 64'(busy), 64'd0);
    checkOutput("busyReq_latchedOp", 64'(lop), 64'd2);
    checkOutput("busyReq_latchedAddr", 64'(laddr), 64'h01_0000_0080);

    // Reset while waiting on the idx 0x10 completion.
    applyStimulus(2'b00, 2'b01, 40'h0, 1, 1, 1'b1, 1'b0, -1, 16);
    checkOutput("rstMid_hit", 64'(didReset), 64'd1);
    checkOutput("rstMid_cmds", 64'(nCmds), 64'd33);
    checkOutput("rstMid_noDone", 64'(doneCnt), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("rstMid_idleBusy", 64'(busy), 64'd0);
    checkOutput("rstMid_idleVld", 64'(vld), 64'd0);
    checkOutput("rstMid_idxCleared", 64'({idx, way}), 64'd0);
    applyStimulus(2'b00, 2'b11, 40'h0, 0, 0, 1'b0, 1'b1, -1, -1);
    checkOutput("allCi_cmds", 64'(nCmds), 64'd256);
    checkOutput("allCi_order", 64'(orderErrs), 64'd0);
    checkOutput("allCi_doneCnt", 64'(doneCnt), 64'd1);
    checkOutput("allCi_doneK", 64'(doneK), 64'd513);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
